axi_read_arbiter: RTL and testbench
===================================

Name: axi_read_arbiter

Overview:
- Two-master, one-slave read-channel arbiter for the AXI fabric.
- Shares one slave read port (AR + R) between M0 (instruction fetch) and M1 (data load) of the CPU wrapper.
- Grants one master at a time, round-robin, and holds the grant from the AR handshake through the RLAST beat.
- Extends the master ID into the slave ID so the slave return path is traceable; flags a burst-length mismatch.

Parameters:
- IDM_BITS, 4, master-side ID width (matches AXI_IDM_BITS).
- IDS_BITS, 8, slave-side ID width (matches AXI_IDS_BITS); must be > IDM_BITS.
- ADDR_BITS, 32, address width.
- DATA_BITS, 32, data width.
- LEN_BITS, 4, burst length width.
- SIZE_BITS, 3, burst size width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- ARID_M0/M1  in  IDM_BITS  master read ID.
- ARADDR_M0/M1  in  ADDR_BITS  read address.
- ARLEN_M0/M1  in  LEN_BITS  burst length - 1.
- ARSIZE_M0/M1  in  SIZE_BITS  beat size.
- ARBURST_M0/M1  in  2  burst type.
- ARVALID_M0/M1  in  1  request valid.
- ARREADY_M0/M1  out  1  request accepted.
- RID_M0/M1  out  IDM_BITS  returned ID.
- RDATA_M0/M1  out  DATA_BITS  read data.
- RRESP_M0/M1  out  2  response.
- RLAST_M0/M1  out  1  last beat.
- RVALID_M0/M1  out  1  data valid.
- RREADY_M0/M1  in  1  master ready.
- ARID_S  out  IDS_BITS  {zero pad, grant index, master ARID}.
- ARADDR_S, ARLEN_S, ARSIZE_S, ARBURST_S  out  as master  granted master's request fields.
- ARVALID_S  out  1  request valid to slave.
- ARREADY_S  in  1  slave accepts request.
- RID_S  in  IDS_BITS  slave returned ID.
- RDATA_S  in  DATA_BITS  slave read data.
- RRESP_S  in  2  slave response.
- RLAST_S  in  1  slave last beat.
- RVALID_S  in  1  slave data valid.
- RREADY_S  out  1  ready to slave, equal to granted master's RREADY.
- prot_err  out  1  sticky burst-length mismatch flag.

Behaviour:
- States:
  - IDLE: no grant.
  - ADDR: AR channel connected to granted master.
  - DATA: R channel connected to granted master.
- Registers: state, grant (1b), last_served (1b), beat_cnt (LEN_BITS), len_q (LEN_BITS), prot_err.
- Reset (rst=1 at clk edge):
  - state=IDLE, grant=0, last_served=1 (so M0 wins first), beat_cnt=0, prot_err=0.
  - Applies even mid-burst; the in-flight burst is abandoned with no drain.
- Outputs in IDLE and during reset: all *_VALID, ARREADY_M*, RREADY_S are 0. Payload outputs may be don't-care but are driven to 0.
- IDLE transitions:
  - One ARVALID_Mx high: grant=x, go ADDR next cycle.
  - Both high: grant = !last_served.
  - Arbitration costs 1 cycle; ARVALID_S rises the cycle after ARVALID_Mx is seen.
- ADDR:
  - ARVALID_S = ARVALID of the granted master; AR fields are the combinational mux of the granted master.
  - ARREADY of the granted master = ARREADY_S; the other master's ARREADY = 0.
  - On ARVALID_S & ARREADY_S: latch len_q = ARLEN, set beat_cnt=0, go DATA.
  - Masters must hold ARVALID once raised (AXI rule); the arbiter does not re-arbitrate in ADDR.
- DATA:
  - Granted master sees RVALID = RVALID_S, plus RDATA, RRESP, RLAST, and RID = RID_S[IDM_BITS-1:0]. The other master's RVALID = 0.
  - RREADY_S = granted master's RREADY.
  - Each beat (RVALID_S & RREADY_S): beat_cnt += 1.
  - Beat with RLAST_S=1: go IDLE, last_served=grant.
  - If beat_cnt != len_q on the RLAST beat, or beat_cnt == len_q on a beat with RLAST_S=0: prot_err=1 (sticky until rst). The state still follows RLAST_S.
- No combinational path from ARVALID_M* to ARVALID_S in IDLE; all ready/valid paths in ADDR and DATA are combinational pass-through.
- Throughput: a single-beat read takes at best 1 (arb) + 1 (AR) + 1 (R) cycles. A new grant cannot start the cycle RLAST completes.

Decomposition:
- Shared package axi_pkg:
  - Width constants (AXI_IDM_BITS, AXI_IDS_BITS, AXI_ADDR_BITS, AXI_DATA_BITS, AXI_LEN_BITS, AXI_SIZE_BITS, AXI_STRB_BITS).
  - Burst and resp encodings.
  - Typedef arb_state_e {IDLE, ADDR, DATA}.
- One natural sub-module: rr_arb2 (2-way round-robin pick from req[1:0] and last_served; combinational, no state).

Test Plan:
- Reset, then M0 only: ARVALID_M0=1, ARADDR=0x0000_0010, ARLEN=0, ARID=3 → ARVALID_S=1 the next cycle with ARID_S=0x03; after a slave single beat RDATA=0xDEADBEEF RLAST=1: RVALID_M0=1, RID_M0=3, RDATA_M0=0xDEADBEEF; RVALID_M1 stays 0.
- Simultaneous request: M0 and M1 raise ARVALID in the same cycle after reset → M0 granted first, M1 second (ARID_S=0x1_ID); a third simultaneous pair → M0 again (alternation).
- Burst of 4 to M1 (ARLEN=3) with RREADY_M1 toggling 1,0,1,0,… → exactly 4 accepted beats routed to M1; M0's ARVALID held high meanwhile gets ARREADY_M0=0 until the cycle after the M1 RLAST beat.
- Length mismatch: ARLEN=1, slave asserts RLAST on the 1st beat → prot_err=1 from the next cycle; state returns IDLE; prot_err persists until rst.
- Reset mid-burst: rst=1 during DATA beat 2 of 4 → next cycle all VALIDs and READYs are 0, state IDLE; the subsequent M1 request is granted normally.
- Slave backpressure: ARREADY_S=0 for 5 cycles → ARVALID_S stays 1 and the AR fields stay stable; the handshake occurs on cycle 6.

Source files
------------

// File: rtl/axi_pkg.sv
// Shared AXI definitions for the CPU wrapper fabric.
// Holds the bus width constants, the burst/response encodings and the read
// arbiter state type. There are no ports; every fabric block imports this package.
package axi_pkg;

  localparam int unsigned AXI_IDM_BITS  = 4;
  localparam int unsigned AXI_IDS_BITS  = 8;
  localparam int unsigned AXI_ADDR_BITS = 32;
  localparam int unsigned AXI_DATA_BITS = 32;
  localparam int unsigned AXI_LEN_BITS  = 4;
  localparam int unsigned AXI_SIZE_BITS = 3;
  localparam int unsigned AXI_STRB_BITS = AXI_DATA_BITS / 8;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA
  } arb_state_e;

endpackage

// File: rtl/axi_read_arbiter_if.sv
// AXI read channel bundle: the AR request and the R return path of one port.
// Modports:
//   master - drives AR fields, arvalid and rready; receives arready and the R beat.
//   slave  - the mirror image: receives the request and drives the R beat.
interface axi_read_arbiter_if
  import axi_pkg::*;
#(
  parameter int unsigned ID_BITS   = AXI_IDM_BITS,
  parameter int unsigned ADDR_BITS = AXI_ADDR_BITS,
  parameter int unsigned DATA_BITS = AXI_DATA_BITS,
  parameter int unsigned LEN_BITS  = AXI_LEN_BITS,
  parameter int unsigned SIZE_BITS = AXI_SIZE_BITS
) ();

  logic [ID_BITS-1:0]   arid;
  logic [ADDR_BITS-1:0] araddr;
  logic [LEN_BITS-1:0]  arlen;
  logic [SIZE_BITS-1:0] arsize;
  logic [1:0]           arburst;
  logic                 arvalid;
  logic                 arready;

  logic [ID_BITS-1:0]   rid;
  logic [DATA_BITS-1:0] rdata;
  logic [1:0]           rresp;
  logic                 rlast;
  logic                 rvalid;
  logic                 rready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arvalid, rready,
    input  arready, rid, rdata, rresp, rlast, rvalid
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
    output arready, rid, rdata, rresp, rlast, rvalid
  );

endinterface

// File: rtl/axi_read_arbiter_rr_arb2.sv
// Two-way round-robin pick, purely combinational.
// Ports:
//   req_i         - request vector, bit x set when master x wants the bus.
//   last_served_i - index of the master that completed the most recent burst.
//   valid_o       - at least one request is present.
//   idx_o         - winning master index (meaningful only when valid_o).
module rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       last_served_i,
  output logic       valid_o,
  output logic       idx_o
);

  always_comb begin
    valid_o = |req_i;
    // A lone requester wins outright; on contention the one not served last wins.
    if (req_i == 2'b11) begin
      idx_o = ~last_served_i;
    end else begin
      idx_o = req_i[1];
    end
  end

endmodule

// File: rtl/axi_read_arbiter.sv
// Two-master, one-slave AXI read arbiter (M0 instruction fetch, M1 data load).
// One master owns the slave port from the AR handshake through its RLAST beat;
// ownership alternates round-robin. The slave-side ID carries the grant index
// above the master ID, and a burst whose RLAST disagrees with ARLEN raises a
// sticky protocol error.
// Ports:
//   clk, rst  - clock and synchronous active-high reset.
//   m0, m1    - master-facing read ports (arbiter acts as their slave).
//   s         - slave-facing read port (arbiter acts as its master).
//   prot_err  - sticky burst-length mismatch flag, cleared only by rst.
module axi_read_arbiter
  import axi_pkg::*;
#(
  parameter int unsigned IDM_BITS  = AXI_IDM_BITS,
  parameter int unsigned IDS_BITS  = AXI_IDS_BITS,
  parameter int unsigned ADDR_BITS = AXI_ADDR_BITS,
  parameter int unsigned DATA_BITS = AXI_DATA_BITS,
  parameter int unsigned LEN_BITS  = AXI_LEN_BITS,
  parameter int unsigned SIZE_BITS = AXI_SIZE_BITS
) (
  input  logic                clk,
  input  logic                rst,
  axi_read_arbiter_if.slave   m0,
  axi_read_arbiter_if.slave   m1,
  axi_read_arbiter_if.master  s,
  output logic                prot_err
);

  arb_state_e          state_q, state_d;
  logic                grant_q, grant_d;
  logic                last_q, last_d;
  logic [LEN_BITS-1:0] beat_q, beat_d;
  logic [LEN_BITS-1:0] len_q, len_d;
  logic                err_q, err_d;

  logic arb_valid, arb_idx;

  rr_arb2 u_rr_arb2 (
    .req_i        ({m1.arvalid, m0.arvalid}),
    .last_served_i(last_q),
    .valid_o      (arb_valid),
    .idx_o        (arb_idx)
  );

  // Request fields and rready of whichever master currently holds the grant.
  logic [IDM_BITS-1:0]  sel_arid;
  logic [ADDR_BITS-1:0] sel_araddr;
  logic [LEN_BITS-1:0]  sel_arlen;
  logic [SIZE_BITS-1:0] sel_arsize;
  logic [1:0]           sel_arburst;
  logic                 sel_arvalid;
  logic                 sel_rready;

  always_comb begin
    if (grant_q) begin
      sel_arid    = m1.arid;
      sel_araddr  = m1.araddr;
      sel_arlen   = m1.arlen;
      sel_arsize  = m1.arsize;
      sel_arburst = m1.arburst;
      sel_arvalid = m1.arvalid;
      sel_rready  = m1.rready;
    end else begin
      sel_arid    = m0.arid;
      sel_araddr  = m0.araddr;
      sel_arlen   = m0.arlen;
      sel_arsize  = m0.arsize;
      sel_arburst = m0.arburst;
      sel_arvalid = m0.arvalid;
      sel_rready  = m0.rready;
    end
  end

  logic [IDS_BITS-1:0] ext_id;
  always_comb begin
    ext_id                = '0;
    ext_id[IDM_BITS-1:0]  = sel_arid;
    ext_id[IDM_BITS]      = grant_q;
  end

  // The slave ID's upper bits are only for tracing on the slave side.
  logic unused_rid;
  assign unused_rid = ^s.rid[IDS_BITS-1:IDM_BITS];

  logic in_addr, in_data, ar_hs, r_hs;
  assign in_addr = ~rst & (state_q == ADDR);
  assign in_data = ~rst & (state_q == DATA);
  assign ar_hs   = in_addr & sel_arvalid & s.arready;
  assign r_hs    = in_data & s.rvalid & sel_rready;

  logic [DATA_BITS-1:0] r_data;
  assign r_data = in_data ? s.rdata : '0;

  // Channel routing: pure pass-through while a grant is held, all zero otherwise.
  always_comb begin
    s.arid     = '0;
    s.araddr   = '0;
    s.arlen    = '0;
    s.arsize   = '0;
    s.arburst  = '0;
    s.arvalid  = 1'b0;
    s.rready   = 1'b0;
    m0.arready = 1'b0;
    m1.arready = 1'b0;
    m0.rid     = '0;
    m0.rdata   = '0;
    m0.rresp   = '0;
    m0.rlast   = 1'b0;
    m0.rvalid  = 1'b0;
    m1.rid     = '0;
    m1.rdata   = '0;
    m1.rresp   = '0;
    m1.rlast   = 1'b0;
    m1.rvalid  = 1'b0;
    if (in_addr) begin
      s.arid    = ext_id;
      s.araddr  = sel_araddr;
      s.arlen   = sel_arlen;
      s.arsize  = sel_arsize;
      s.arburst = sel_arburst;
      s.arvalid = sel_arvalid;
      if (grant_q) m1.arready = s.arready;
      else         m0.arready = s.arready;
    end
    if (in_data) begin
      s.rready = sel_rready;
      if (grant_q) begin
        m1.rid    = s.rid[IDM_BITS-1:0];
        m1.rdata  = r_data;
        m1.rresp  = s.rresp;
        m1.rlast  = s.rlast;
        m1.rvalid = s.rvalid;
      end else begin
        m0.rid    = s.rid[IDM_BITS-1:0];
        m0.rdata  = r_data;
        m0.rresp  = s.rresp;
        m0.rlast  = s.rlast;
        m0.rvalid = s.rvalid;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    beat_d  = beat_q;
    len_d   = len_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (arb_valid) begin
          grant_d = arb_idx;
          state_d = ADDR;
        end
      end
      ADDR: begin
        if (ar_hs) begin
          len_d   = sel_arlen;
          beat_d  = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (r_hs) begin
          beat_d = beat_q + 1'b1;
          // RLAST must land exactly on beat len_q; the FSM still trusts RLAST.
          if (s.rlast != (beat_q == len_q)) err_d = 1'b1;
          if (s.rlast) begin
            state_d = IDLE;
            last_d  = grant_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
      beat_q  <= '0;
      len_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      beat_q  <= beat_d;
      len_q   <= len_d;
      err_q   <= err_d;
    end
  end

  assign prot_err = err_q;

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Self-checking bench for axi_read_arbiter: an arbitration vector table,
// hand-written corner sequences and a randomized transaction-level run.
module tb_axi_read_arbiter;
  import axi_pkg::*;

  localparam int unsigned IDM = 4;
  localparam int unsigned IDS = 8;
  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 32;
  localparam int unsigned LW  = 4;
  localparam int unsigned SW  = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic prot_err;
  always #5 clk = ~clk;

  axi_read_arbiter_if #(.ID_BITS(IDM), .ADDR_BITS(AW), .DATA_BITS(DW), .LEN_BITS(LW),
                        .SIZE_BITS(SW)) m0_if ();
  axi_read_arbiter_if #(.ID_BITS(IDM), .ADDR_BITS(AW), .DATA_BITS(DW), .LEN_BITS(LW),
                        .SIZE_BITS(SW)) m1_if ();
  axi_read_arbiter_if #(.ID_BITS(IDS), .ADDR_BITS(AW), .DATA_BITS(DW), .LEN_BITS(LW),
                        .SIZE_BITS(SW)) s_if ();

  axi_read_arbiter #(
    .IDM_BITS(IDM), .IDS_BITS(IDS), .ADDR_BITS(AW), .DATA_BITS(DW), .LEN_BITS(LW),
    .SIZE_BITS(SW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .m0      (m0_if),
    .m1      (m1_if),
    .s       (s_if),
    .prot_err(prot_err)
  );

  // Master-side stimulus, indexed by master number.
  logic [1:0]     m_arvalid, m_rready;
  logic [IDM-1:0] m_arid    [2];
  logic [AW-1:0]  m_araddr  [2];
  logic [LW-1:0]  m_arlen   [2];
  logic [SW-1:0]  m_arsize  [2];
  logic [1:0]     m_arburst [2];
  // Master-side observations.
  logic [1:0]     m_arready, m_rvalid, m_rlast;
  logic [IDM-1:0] m_rid     [2];
  logic [DW-1:0]  m_rdata   [2];
  logic [1:0]     m_rresp   [2];
  // Slave-side stimulus.
  logic           s_arready, s_rvalid, s_rlast;
  logic [IDS-1:0] s_rid;
  logic [DW-1:0]  s_rdata;
  logic [1:0]     s_rresp;

  assign m0_if.arid = m_arid[0];     assign m1_if.arid = m_arid[1];
  assign m0_if.araddr = m_araddr[0]; assign m1_if.araddr = m_araddr[1];
  assign m0_if.arlen = m_arlen[0];   assign m1_if.arlen = m_arlen[1];
  assign m0_if.arsize = m_arsize[0]; assign m1_if.arsize = m_arsize[1];
  assign m0_if.arburst = m_arburst[0];
  assign m1_if.arburst = m_arburst[1];
  assign m0_if.arvalid = m_arvalid[0];
  assign m1_if.arvalid = m_arvalid[1];
  assign m0_if.rready = m_rready[0]; assign m1_if.rready = m_rready[1];

  assign m_arready = {m1_if.arready, m0_if.arready};
  assign m_rvalid  = {m1_if.rvalid, m0_if.rvalid};
  assign m_rlast   = {m1_if.rlast, m0_if.rlast};
  assign m_rid[0] = m0_if.rid;     assign m_rid[1] = m1_if.rid;
  assign m_rdata[0] = m0_if.rdata; assign m_rdata[1] = m1_if.rdata;
  assign m_rresp[0] = m0_if.rresp; assign m_rresp[1] = m1_if.rresp;

  assign s_if.arready = s_arready;
  assign s_if.rid     = s_rid;
  assign s_if.rdata   = s_rdata;
  assign s_if.rresp   = s_rresp;
  assign s_if.rlast   = s_rlast;
  assign s_if.rvalid  = s_rvalid;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs change 1 unit after the rising edge; checks run 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Slave ID layout: {zero pad, grant index, master ID}.
  function automatic logic [IDS-1:0] sid(input logic g, input logic [IDM-1:0] id);
    return {{(IDS - IDM - 1){1'b0}}, g, id};
  endfunction

  task automatic clear_inputs();
    m_arvalid = '0;
    m_rready  = '0;
    for (int i = 0; i < 2; i++) begin
      m_arid[i] = '0; m_araddr[i] = '0; m_arlen[i] = '0;
      m_arsize[i] = 3'd2; m_arburst[i] = BURST_INCR;
    end
    s_arready = 1'b0; s_rvalid = 1'b0; s_rlast = 1'b0;
    s_rid = '0; s_rdata = '0; s_rresp = RESP_OKAY;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Grant g is in DATA: the slave returns n beats back to back, master always ready.
  task automatic send_beats(input logic g, input int n, input logic [DW-1:0] base);
    for (int k = 0; k < n; k++) begin
      s_rvalid = 1'b1;
      s_rdata  = base + DW'(k);
      s_rlast  = (k == n - 1);
      s_rid    = sid(g, m_arid[g]);
      s_rresp  = RESP_OKAY;
      m_rready = g ? 2'b10 : 2'b01;
      #1;
      check("beat_rvalid", m_rvalid[g], 1'b1);
      check("beat_other_rvalid", m_rvalid[~g], 1'b0);
      check("beat_rdata", m_rdata[g], base + DW'(k));
      check("beat_rid", m_rid[g], m_arid[g]);
      check("beat_rlast", m_rlast[g], (k == n - 1));
      tick();
    end
    s_rvalid = 1'b0;
    s_rlast  = 1'b0;
    m_rready = '0;
  endtask

  typedef struct {
    logic [1:0] req;
    logic       exp_valid;
    logic       exp_grant;
  } arb_vec_t;

  arb_vec_t vecs[9];

  // Randomized run state.
  logic [AW-1:0]  q_addr  [2][16];
  logic [IDM-1:0] q_id    [2][16];
  logic [LW-1:0]  q_len   [2][16];
  logic [SW-1:0]  q_size  [2][16];
  logic [1:0]     q_burst [2][16];
  int nreq[2];
  int head[2];
  int exp_order[$];

  initial begin
    logic g;
    logic rr;
    int   k, seen;

    // Round-robin expectations, starting from reset where M0 is favoured.
    vecs[0] = '{req: 2'b11, exp_valid: 1'b1, exp_grant: 1'b0};
    vecs[1] = '{req: 2'b11, exp_valid: 1'b1, exp_grant: 1'b1};
    vecs[2] = '{req: 2'b11, exp_valid: 1'b1, exp_grant: 1'b0};
    vecs[3] = '{req: 2'b01, exp_valid: 1'b1, exp_grant: 1'b0};
    vecs[4] = '{req: 2'b10, exp_valid: 1'b1, exp_grant: 1'b1};
    vecs[5] = '{req: 2'b10, exp_valid: 1'b1, exp_grant: 1'b1};
    vecs[6] = '{req: 2'b11, exp_valid: 1'b1, exp_grant: 1'b0};
    vecs[7] = '{req: 2'b11, exp_valid: 1'b1, exp_grant: 1'b1};
    vecs[8] = '{req: 2'b00, exp_valid: 1'b0, exp_grant: 1'b0};

    // Reset state, with both masters requesting and the slave offering data.
    clear_inputs();
    m_arvalid = 2'b11;
    s_arready = 1'b1;
    s_rvalid  = 1'b1;
    m_rready  = 2'b11;
    tick();
    check("rst_arvalid_s", s_if.arvalid, 1'b0);
    check("rst_arready_m", m_arready, 2'b00);
    check("rst_rvalid_m", m_rvalid, 2'b00);
    check("rst_rready_s", s_if.rready, 1'b0);
    check("rst_arid_s", s_if.arid, '0);
    check("rst_prot_err", prot_err, 1'b0);
    do_reset();

    // Arbitration table.
    for (int i = 0; i < 9; i++) begin
      m_arid[0] = 4'd3;  m_araddr[0] = 32'h0000_0010; m_arlen[0] = '0;
      m_arid[1] = 4'd5;  m_araddr[1] = 32'h2000 + AW'(i * 16); m_arlen[1] = '0;
      m_arvalid = vecs[i].req;
      #1;
      check("idle_no_comb_arvalid", s_if.arvalid, 1'b0);
      tick();
      check("arb_arvalid_s", s_if.arvalid, vecs[i].exp_valid);
      if (vecs[i].exp_valid) begin
        g = vecs[i].exp_grant;
        check("arb_arid_s", s_if.arid, sid(g, m_arid[g]));
        check("arb_araddr_s", s_if.araddr, m_araddr[g]);
        s_arready = 1'b1;
        #1;
        check("arb_arready_win", m_arready[g], 1'b1);
        check("arb_arready_lose", m_arready[~g], 1'b0);
        tick();
        m_arvalid = '0;
        s_arready = 1'b0;
        send_beats(g, 1, 32'hDEAD_BEEF);
      end else begin
        m_arvalid = '0;
      end
    end

    // Burst of 4 to M1 with toggling rready while M0 waits.
    do_reset();
    m_arid[1] = 4'd7; m_arlen[1] = 4'd3; m_araddr[1] = 32'h400;
    m_arvalid = 2'b10;
    tick();
    m_arid[0] = 4'd2; m_arlen[0] = 4'd0; m_araddr[0] = 32'h80;
    m_arvalid = 2'b11;
    s_arready = 1'b1;
    #1;
    check("b4_arready_m1", m_arready[1], 1'b1);
    check("b4_arready_m0", m_arready[0], 1'b0);
    check("b4_arid_s", s_if.arid, sid(1'b1, 4'd7));
    tick();
    m_arvalid = 2'b01;
    k = 0; seen = 0; rr = 1'b1;
    for (int c = 0; c < 20 && k < 4; c++) begin
      s_rvalid = 1'b1;
      s_rdata  = 32'h1000 + DW'(k);
      s_rlast  = (k == 3);
      s_rid    = sid(1'b1, 4'd7);
      m_rready = {rr, 1'b1};
      #1;
      check("b4_m0_arready", m_arready[0], 1'b0);
      check("b4_m0_rvalid", m_rvalid[0], 1'b0);
      check("b4_m1_rdata", m_rdata[1], 32'h1000 + DW'(k));
      check("b4_rready_s", s_if.rready, rr);
      if (m_rvalid[1] && m_rready[1]) seen++;
      if (rr) k++;
      rr = ~rr;
      tick();
    end
    check("b4_beats", seen, 4);
    s_rvalid = 1'b0; s_rlast = 1'b0; m_rready = '0;
    #1;
    check("b4_m0_arready_idle", m_arready[0], 1'b0);
    check("b4_arvalid_s_idle", s_if.arvalid, 1'b0);
    tick();
    check("b4_m0_arready_grant", m_arready[0], 1'b1);
    check("b4_m0_arid_s", s_if.arid, sid(1'b0, 4'd2));
    tick();
    m_arvalid = '0; s_arready = 1'b0;
    send_beats(1'b0, 1, 32'h55AA_0000);
    check("b4_prot_err", prot_err, 1'b0);

    // Length mismatch: ARLEN=1 but RLAST on the first beat.
    do_reset();
    m_arid[0] = 4'd1; m_arlen[0] = 4'd1; m_arvalid = 2'b01;
    tick();
    s_arready = 1'b1;
    tick();
    m_arvalid = '0; s_arready = 1'b0;
    s_rvalid = 1'b1; s_rlast = 1'b1; s_rdata = 32'h1234; m_rready = 2'b01;
    #1;
    check("mm_err_before", prot_err, 1'b0);
    tick();
    s_rvalid = 1'b0; s_rlast = 1'b0;
    #1;
    check("mm_err_set", prot_err, 1'b1);
    check("mm_idle_rready_s", s_if.rready, 1'b0);
    m_rready = '0;
    m_arlen[0] = 4'd0; m_arvalid = 2'b01;
    tick();
    s_arready = 1'b1;
    tick();
    m_arvalid = '0; s_arready = 1'b0;
    send_beats(1'b0, 1, 32'h0BAD_0000);
    check("mm_err_sticky", prot_err, 1'b1);
    do_reset();
    #1;
    check("mm_err_cleared", prot_err, 1'b0);

    // Mismatch the other way: ARLEN=0, first beat without RLAST.
    m_arid[1] = 4'd4; m_arlen[1] = 4'd0; m_arvalid = 2'b10;
    tick();
    s_arready = 1'b1;
    tick();
    m_arvalid = '0; s_arready = 1'b0;
    s_rvalid = 1'b1; s_rlast = 1'b0; m_rready = 2'b10;
    tick();
    check("mm2_err_set", prot_err, 1'b1);
    s_rlast = 1'b1;
    tick();
    s_rvalid = 1'b0; s_rlast = 1'b0; m_rready = '0;

    // Reset in the middle of a 4-beat burst to M0.
    do_reset();
    m_arid[0] = 4'd6; m_arlen[0] = 4'd3; m_arvalid = 2'b01;
    tick();
    s_arready = 1'b1;
    tick();
    m_arvalid = '0; s_arready = 1'b0;
    s_rvalid = 1'b1; s_rlast = 1'b0; s_rdata = 32'hA0; m_rready = 2'b01;
    tick();
    s_rdata = 32'hA1;
    rst = 1'b1;
    #1;
    check("mid_rst_rvalid", m_rvalid, 2'b00);
    tick();
    rst = 1'b0;
    #1;
    check("mid_rst_rvalid_after", m_rvalid, 2'b00);
    check("mid_rst_rready_s", s_if.rready, 1'b0);
    check("mid_rst_arvalid_s", s_if.arvalid, 1'b0);
    check("mid_rst_arready", m_arready, 2'b00);
    s_rvalid = 1'b0; m_rready = '0;
    m_arid[1] = 4'd9; m_arvalid = 2'b10; m_arlen[1] = 4'd0;
    tick();
    check("mid_rst_m1_arvalid_s", s_if.arvalid, 1'b1);
    check("mid_rst_m1_arid_s", s_if.arid, sid(1'b1, 4'd9));
    s_arready = 1'b1;
    tick();
    m_arvalid = '0; s_arready = 1'b0;
    send_beats(1'b1, 1, 32'hCAFE_0000);
    check("mid_rst_prot_err", prot_err, 1'b0);

    // Slave AR backpressure for 5 cycles.
    do_reset();
    m_arid[0] = 4'hB; m_araddr[0] = 32'hF00D_0040; m_arlen[0] = 4'd2;
    m_arsize[0] = 3'd1; m_arburst[0] = BURST_WRAP; m_arvalid = 2'b01;
    tick();
    for (int c = 0; c < 5; c++) begin
      #1;
      check("bp_arvalid_s", s_if.arvalid, 1'b1);
      check("bp_araddr_s", s_if.araddr, 32'hF00D_0040);
      check("bp_arlen_s", s_if.arlen, 4'd2);
      check("bp_arburst_s", s_if.arburst, BURST_WRAP);
      check("bp_arready_m0", m_arready[0], 1'b0);
      tick();
    end
    s_arready = 1'b1;
    #1;
    check("bp_arready_hs", m_arready[0], 1'b1);
    check("bp_arid_s", s_if.arid, sid(1'b0, 4'hB));
    tick();
    m_arvalid = '0; s_arready = 1'b0;
    send_beats(1'b0, 3, 32'h7700_0000);
    check("bp_prot_err", prot_err, 1'b0);

    // Randomized run: both masters keep requests queued; the slave answers
    // with legal bursts at random pace.
    do_reset();
    begin
      int a, b, turn, p, owner, beats_left, done, ar_idx, total;
      logic [IDM-1:0] cur_id;
      bit r_clear;
      for (int m = 0; m < 2; m++) begin
        nreq[m] = $urandom_range(4, 12);
        head[m] = 0;
        for (int j = 0; j < 16; j++) begin
          q_addr[m][j]  = $urandom;
          q_id[m][j]    = IDM'($urandom);
          q_len[m][j]   = LW'($urandom_range(0, 7));
          q_size[m][j]  = SW'($urandom);
          q_burst[m][j] = 2'($urandom);
        end
      end
      // Grant order: strict alternation while both have work, M0 first.
      a = nreq[0]; b = nreq[1]; turn = 0;
      while (a > 0 || b > 0) begin
        p = (a > 0 && (b == 0 || turn == 0)) ? 0 : 1;
        exp_order.push_back(p);
        if (p == 0) a--; else b--;
        turn = 1 - p;
      end
      total = nreq[0] + nreq[1];
      owner = 0; beats_left = 0; done = 0; ar_idx = 0; r_clear = 0; cur_id = '0;
      for (int cyc = 0; cyc < 5000 && done < total; cyc++) begin
        if (r_clear) begin
          s_rvalid = 1'b0; s_rlast = 1'b0; r_clear = 0;
        end
        for (int m = 0; m < 2; m++) begin
          m_arvalid[m] = (head[m] < nreq[m]);
          if (head[m] < nreq[m]) begin
            m_arid[m]    = q_id[m][head[m]];
            m_araddr[m]  = q_addr[m][head[m]];
            m_arlen[m]   = q_len[m][head[m]];
            m_arsize[m]  = q_size[m][head[m]];
            m_arburst[m] = q_burst[m][head[m]];
          end
          m_rready[m] = ($urandom_range(0, 3) != 0);
        end
        s_arready = ($urandom_range(0, 3) != 0);
        if (beats_left > 0 && !s_rvalid && $urandom_range(0, 3) != 0) begin
          s_rvalid = 1'b1;
          s_rdata  = $urandom;
          s_rresp  = 2'($urandom);
          s_rlast  = (beats_left == 1);
          s_rid    = sid(1'(owner), cur_id);
        end
        #1;
        if (s_if.arvalid && s_arready) begin
          check("rnd_ar_in_budget", 64'(ar_idx < total), 1);
          p = (ar_idx < total) ? exp_order[ar_idx] : 0;
          check("rnd_arid_s", s_if.arid, sid(1'(p), m_arid[p]));
          check("rnd_araddr_s", s_if.araddr, m_araddr[p]);
          check("rnd_arlen_s", s_if.arlen, m_arlen[p]);
          check("rnd_arsize_s", s_if.arsize, m_arsize[p]);
          check("rnd_arburst_s", s_if.arburst, m_arburst[p]);
          check("rnd_arready_win", m_arready[p], 1'b1);
          check("rnd_arready_lose", m_arready[1-p], 1'b0);
          head[p]++;
          owner = p;
          cur_id = m_arid[p];
          beats_left = int'(m_arlen[p]) + 1;
          ar_idx++;
        end
        if (s_rvalid) begin
          check("rnd_rvalid_own", m_rvalid[owner], 1'b1);
          check("rnd_rvalid_other", m_rvalid[1-owner], 1'b0);
          check("rnd_rdata", m_rdata[owner], s_rdata);
          check("rnd_rid", m_rid[owner], cur_id);
          check("rnd_rresp", m_rresp[owner], s_rresp);
          check("rnd_rlast", m_rlast[owner], s_rlast);
          check("rnd_rready_s", s_if.rready, m_rready[owner]);
          if (m_rready[owner]) begin
            beats_left--;
            r_clear = 1;
            if (beats_left == 0) done++;
          end
        end else begin
          check("rnd_no_rvalid", m_rvalid, 2'b00);
        end
        tick();
      end
      check("rnd_all_done", done, total);
      check("rnd_prot_err", prot_err, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
